// File: rtl/rx_frame_sync_pkg.sv
// Shared types and constants for the rx_frame_sync deframer slice.
package rx_frame_pkg;

    typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CRC} state_t;

    localparam logic [31:0] DEF_SYNC_WORD = 32'h1ACFFC1D;
    localparam logic [15:0] CRC_POLY      = 16'h1021;
    localparam logic [15:0] CRC_INIT      = 16'hFFFF;
    localparam int unsigned LEN_W         = 8;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int unsigned i = 0; i < 32; i++) n = n + {5'b0, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/rx_frame_sync_if.sv
// Bit-in / byte-out stream bundle of the deframer; slave is the deframer side.
interface rx_frame_sync_if;
    logic       in_valid;
    logic       in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       locked;
    logic       frame_err;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, locked, frame_err
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, locked, frame_err
    );
endinterface

// File: rtl/rx_frame_sync_crc16.sv
// Serial CRC-16-CCITT, MSB-first; only built when CRC_CHECK_EN is defined.
`ifdef CRC_CHECK_EN
module crc16_serial
    import rx_frame_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic        i_bit,
    output logic [15:0] o_crc
);
    logic [15:0] r_crc;
    logic        w_fb;

    assign w_fb  = r_crc[15] ^ i_bit;
    assign o_crc = r_crc;

    always_ff @(posedge clk) begin
        if (rst || i_clr)
            r_crc <= CRC_INIT;
        else if (i_en)
            r_crc <= {r_crc[14:0], 1'b0} ^ (w_fb ? CRC_POLY : '0);
    end
endmodule
`endif

// File: rtl/rx_frame_sync.sv
// Sync-marker hunter and length-framed deframer: 1-bit stream in, AXI-Stream bytes out.
// Optional trailing CRC-16 check is enabled with the CRC_CHECK_EN macro.
module rx_frame_sync
    import rx_frame_pkg::*;
#(
    parameter logic [31:0] SYNC_WORD    = DEF_SYNC_WORD,
    parameter int unsigned SYNC_MAX_ERR = 0
)(
    input  logic            clk,
    input  logic            rst,
    rx_frame_sync_if.slave  bus
);
    localparam logic [5:0] MAX_ERR = 6'(SYNC_MAX_ERR);

    state_t           r_state;
    logic [31:0]      r_shreg;
    logic [5:0]       r_bitcnt;
    logic [7:0]       r_asm;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_bytecnt;
    logic             r_out_valid;
    logic [7:0]       r_out_data;
    logic             r_out_last;
    logic             r_locked;

    logic             w_full;
    logic             w_in_ready;
    logic             w_accept;
    logic [31:0]      w_shreg_next;
    logic [7:0]       w_asm_next;
    logic             w_sync_hit;
    logic             w_last_byte;

    assign w_full       = r_out_valid && !bus.out_ready;
    assign w_accept     = bus.in_valid && w_in_ready;
    assign w_shreg_next = {r_shreg[30:0], bus.in_data};
    assign w_asm_next   = {r_asm[6:0], bus.in_data};
    // r_bitcnt >= 31 means the bit being accepted is at least the 32nd since the last frame
    assign w_sync_hit   = (r_bitcnt >= 6'd31) && (popcount32(w_shreg_next ^ SYNC_WORD) <= MAX_ERR);
    assign w_last_byte  = (r_bytecnt + LEN_W'(1)) == r_len;

    always_comb begin
        w_in_ready = 1'b1;
        if (r_state == PAYLOAD || r_state == CRC) w_in_ready = !w_full;
    end

`ifdef CRC_CHECK_EN
    logic [15:0] r_crc_rx;
    logic        r_frame_err;
    logic [15:0] w_crc;
    logic [15:0] w_crc_rx_next;

    assign w_crc_rx_next = {r_crc_rx[14:0], bus.in_data};

    crc16_serial u_crc (
        .clk   (clk),
        .rst   (rst),
        .i_clr (r_state == LEN),
        .i_en  (w_accept && r_state == PAYLOAD),
        .i_bit (bus.in_data),
        .o_crc (w_crc)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HUNT;
            r_shreg     <= '0;
            r_bitcnt    <= '0;
            r_asm       <= '0;
            r_len       <= '0;
            r_bytecnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_locked    <= 1'b0;
`ifdef CRC_CHECK_EN
            r_crc_rx    <= '0;
            r_frame_err <= 1'b0;
`endif
        end else begin
            if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
`ifdef CRC_CHECK_EN
            r_frame_err <= 1'b0;
`endif
            if (w_accept) begin
                case (r_state)
                    HUNT: begin
                        r_shreg <= w_shreg_next;
                        if (r_bitcnt != 6'd32) r_bitcnt <= r_bitcnt + 6'd1;
                        if (w_sync_hit) begin
                            r_state  <= LEN;
                            r_locked <= 1'b1;
                            r_bitcnt <= '0;
                        end
                    end
                    LEN: begin
                        r_asm    <= w_asm_next;
                        r_bitcnt <= r_bitcnt + 6'd1;
                        if (r_bitcnt[2:0] == 3'd7) begin
                            r_bitcnt <= '0;
                            if (w_asm_next == '0) begin
                                r_state  <= HUNT;
                                r_locked <= 1'b0;
                                r_shreg  <= '0;
                            end else begin
                                r_len     <= w_asm_next;
                                r_bytecnt <= '0;
                                r_state   <= PAYLOAD;
                            end
                        end
                    end
                    PAYLOAD: begin
                        r_asm    <= w_asm_next;
                        r_bitcnt <= r_bitcnt + 6'd1;
                        if (r_bitcnt[2:0] == 3'd7) begin
                            r_bitcnt  <= '0;
                            r_bytecnt <= r_bytecnt + LEN_W'(1);
`ifdef CRC_CHECK_EN
                            // last byte stays in r_asm until the CRC has been checked
                            if (w_last_byte) begin
                                r_state <= CRC;
                            end else begin
                                r_out_valid <= 1'b1;
                                r_out_data  <= w_asm_next;
                                r_out_last  <= 1'b0;
                            end
`else
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_asm_next;
                            r_out_last  <= w_last_byte;
                            if (w_last_byte) begin
                                r_state  <= HUNT;
                                r_locked <= 1'b0;
                                r_shreg  <= '0;
                            end
`endif
                        end
                    end
`ifdef CRC_CHECK_EN
                    CRC: begin
                        r_crc_rx <= w_crc_rx_next;
                        r_bitcnt <= r_bitcnt + 6'd1;
                        if (r_bitcnt[3:0] == 4'd15) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= r_asm;
                            r_out_last  <= 1'b1;
                            r_frame_err <= (w_crc_rx_next != w_crc);
                            r_state     <= HUNT;
                            r_locked    <= 1'b0;
                            r_shreg     <= '0;
                            r_bitcnt    <= '0;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.locked    = r_locked;
`ifdef CRC_CHECK_EN
    assign bus.frame_err = r_frame_err;
`else
    assign bus.frame_err = 1'b0;
`endif

endmodule
